fetch_insn_queue: RTL and testbench
===================================

// Module: fetch_insn_queue
// PURPOSE
//  Sits directly downstream of the fetch unit. Drives nextPc/flush/stall toward it and consumes its
//  valid/fault/pc/iCacheLine responses. Slices each accepted cache line into 32-bit instructions
//  (from fuPc word offset to line end) and queues {pc, insn, fault} entries for decode.
//  Redirects from execute flush the queue and stale in-flight responses.
// PARAMETERS
//  LINE_WIDTH  128            icache line width in bits; power of two, >= 64
//  DEPTH       4              queue entries; power of two, >= 2
//  RESET_PC    32'h8000_0000  first fetch address after reset
// PORTS
//  clk            in   1           clock
//  rstN           in   1           asynchronous active-low reset
//  redirectValid  in   1           execute-stage control-flow redirect
//  redirectPc     in   32          redirect target; bits [1:0] ignored
//  fuNextPc       out  32          address fetch unit samples when !fuStall
//  fuFlush        out  1           kill fetch unit in-flight work
//  fuStall        out  1           hold fetch unit
//  fuValid        in   1           response valid
//  fuFault        in   1           response is a fetch fault (page/access)
//  fuPc           in   32          response address
//  fuLine         in   LINE_WIDTH  response cache line
//  outValid       out  1           head entry valid toward decode
//  outReady       in   1           decode accepts head
//  outPc          out  32          head pc
//  outInsn        out  32          head instruction (0 when outFault)
//  outFault       out  1           head is a fault marker
// BEHAVIOUR
//  Reset (async, rstN=0): queue empty, outValid=0, outPc/outInsn/outFault=0, fuFlush=0, fuStall=0,
//   fuNextPc=RESET_PC, expectPc=RESET_PC, state=RUN. All regs async-reset, no X on any output.
//  WPL = LINE_WIDTH/32 words per line; word index = pc[$clog2(LINE_WIDTH/8)-1:2].
//  Response accept: fuValid && fuPc==expectPc && state==RUN && !redirectValid; else dropped silently.
//  States:
//   RUN   - accept response; fault -> enqueue {fuPc,0,1}, go HALT; else latch line,
//           drainPc=fuPc, go DRAIN. fuNextPc/expectPc advance to line base of fuPc + LINE_WIDTH/8.
//   DRAIN - each cycle queue not full: enqueue word[drainPc idx] at drainPc, drainPc+=4;
//           last word of line enqueued -> RUN. Wrap: index never exceeds WPL-1 (0xFFFF_FFF0 line ok,
//           next line base wraps to 0).
//   HALT  - no accept, no enqueue; exit only via redirect.
//  fuStall = (state!=RUN) || (freeSlots < 2).
//  Redirect (any state, highest priority): same cycle fuFlush=1, fuNextPc=redirectPc&~3;
//   next edge: queue emptied, line buffer discarded, expectPc=redirectPc&~3, state=RUN.
//   Dequeue in redirect cycle still counts if outValid&&outReady. fuFlush is 1 cycle only.
//  Queue: enqueue/dequeue same cycle when full permitted (dequeue frees slot first).
//   Head stable while outValid && !outReady.
//  Enqueue-to-outValid latency: 1 cycle (see CONFIGURATION).
// CONFIGURATION
//  FETCH_INSN_QUEUE_BYPASS_EN defined: entry enqueued into empty queue appears on out* same cycle
//   (combinational bypass); if outReady, it is not written. Latency 0.
//  Not defined: out* driven only from queue registers; latency 1; no fuLine->outInsn comb path.
// STRUCTURE
//  Package FetchTypes: fetch_entry_t {vaddr_t pc; insn_t insn; logic fault;},
//   fetch_queue_state_t enum {RUN, DRAIN, HALT}, WORDS_PER_LINE, line offset widths.
//  Sub-module fetch_entry_fifo #(DEPTH): circular FIFO of fetch_entry_t with
//   enq/deq/full/empty/freeCount/clear; clear has priority over enq.
//  Top: FSM, line buffer, expectPc/drainPc regs, fetch-unit control, optional bypass mux.
// TESTING
//  1 Reset release, fuValid pc=0x8000_0000 line words {A,B,C,D}, outReady=1 -> outs A..D at
//    pc 0x8000_0000..0x8000_000C, fuNextPc=0x8000_0010 after accept.
//  2 Response pc=0x8000_0008 -> only C,D enqueued (pcs ..08, ..0C); state back to RUN after 2 cycles.
//  3 outReady=0 for 10 cycles, DEPTH=4 -> queue holds 4, fuStall=1, outPc steady; release -> no loss/dup.
//  4 Redirect to 0x8000_0102 mid-DRAIN -> fuFlush 1 cycle, fuNextPc=0x8000_0100, queue empty
//    next cycle; late response pc=0x8000_0010 dropped.
//  5 fuFault at pc 0x8000_2000 -> one entry outFault=1 outInsn=0, state HALT, fuStall=1
//    until redirect.
//  6 Reset asserted mid-DRAIN with queue full -> all outputs to reset values immediately (async);
//    repeat 1-5 with and without FETCH_INSN_QUEUE_BYPASS_EN.

Source files
------------

// File: rtl/fetch_insn_queue_pkg.sv
// Shared types and line-geometry helpers for the fetch instruction queue.
package fetch_insn_queue_pkg;

  typedef logic [31:0] vaddr_t;
  typedef logic [31:0] insn_t;

  typedef struct packed {
    vaddr_t pc;
    insn_t  insn;
    logic   fault;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_queue_state_t;

  localparam int unsigned DEFAULT_LINE_WIDTH = 128;
  localparam int unsigned DEFAULT_DEPTH      = 4;
  localparam vaddr_t      DEFAULT_RESET_PC   = 32'h8000_0000;

  function automatic int unsigned words_per_line(input int unsigned line_width);
    return line_width / 32;
  endfunction

  // Byte-offset bits inside a line, and the word-index bits within those.
  function automatic int unsigned line_offset_bits(input int unsigned line_width);
    return $clog2(line_width / 8);
  endfunction

  function automatic int unsigned word_index_bits(input int unsigned line_width);
    return $clog2(line_width / 32);
  endfunction

endpackage

// File: rtl/fetch_insn_queue_fifo.sv
// Circular FIFO of fetch entries; clear wins over enqueue, a full FIFO may
// enqueue in the same cycle it dequeues.
module fetch_entry_fifo
  import fetch_insn_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rstN_i,
  input  logic                     clear_i,
  input  logic                     enq_i,
  input  fetch_entry_t             enqData_i,
  input  logic                     deq_i,
  output fetch_entry_t             deqData_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   freeCount_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW:0]   count_q, count_d;
  logic          doEnq, doDeq;

  assign full_o      = (count_q == DEPTH_C);
  assign empty_o     = (count_q == '0);
  assign freeCount_o = DEPTH_C - count_q;
  assign deqData_o   = mem_q[rdPtr_q];

  assign doDeq = deq_i && !empty_o;
  assign doEnq = enq_i && (!full_o || doDeq);

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (clear_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (doDeq) rdPtr_d = rdPtr_q + PW'(1);
      if (doEnq) wrPtr_d = wrPtr_q + PW'(1);
      count_d = count_q + (PW + 1)'(doEnq) - (PW + 1)'(doDeq);
    end
  end

  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      if (doEnq && !clear_i) mem_q[wrPtr_q] <= enqData_i;
    end
  end

endmodule

// File: rtl/fetch_insn_queue.sv
// Slices fetched cache lines into per-instruction queue entries for decode.
// FETCH_INSN_QUEUE_BYPASS_EN: zero-latency bypass of an empty queue onto out*.
module fetch_insn_queue
  import fetch_insn_queue_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = DEFAULT_LINE_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter vaddr_t      RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic                  clk_i,
  input  logic                  rstN_i,
  input  logic                  redirectValid_i,
  input  logic [31:0]           redirectPc_i,
  output logic [31:0]           fuNextPc_o,
  output logic                  fuFlush_o,
  output logic                  fuStall_o,
  input  logic                  fuValid_i,
  input  logic                  fuFault_i,
  input  logic [31:0]           fuPc_i,
  input  logic [LINE_WIDTH-1:0] fuLine_i,
  output logic                  outValid_o,
  input  logic                  outReady_i,
  output logic [31:0]           outPc_o,
  output logic [31:0]           outInsn_o,
  output logic                  outFault_o
);

  localparam int unsigned WPL   = words_per_line(LINE_WIDTH);
  localparam int unsigned OFF_W = line_offset_bits(LINE_WIDTH);
  localparam int unsigned IDX_W = word_index_bits(LINE_WIDTH);
  localparam int unsigned FC_W  = $clog2(DEPTH) + 1;
  localparam vaddr_t          LINE_BYTES = 32'(LINE_WIDTH / 8);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WPL - 1);

  fetch_queue_state_t    state_q, state_d;
  vaddr_t                expectPc_q, expectPc_d;
  vaddr_t                drainPc_q, drainPc_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;

  logic [31:0]      lineWord [WPL];
  logic [IDX_W-1:0] drainIdx;
  logic             accept, canEnq, enqValid, fifoEnq;
  fetch_entry_t     enqEntry, fifoHead, headEntry;
  logic             fifoFull, fifoEmpty;
  logic [FC_W-1:0]  freeCount;

  for (genvar gi = 0; gi < WPL; gi++) begin : g_word
    assign lineWord[gi] = line_q[gi*32 +: 32];
  end

  assign drainIdx = drainPc_q[OFF_W-1:2];
  assign accept   = fuValid_i && (fuPc_i == expectPc_q) && (state_q == RUN) && !redirectValid_i;
  // A slot is usable if free now or freed by this cycle's dequeue.
  assign canEnq   = !fifoFull || (!fifoEmpty && outReady_i);

  always_comb begin
    state_d    = state_q;
    expectPc_d = expectPc_q;
    drainPc_d  = drainPc_q;
    line_d     = line_q;
    enqValid   = 1'b0;
    enqEntry   = '0;
    if (redirectValid_i) begin
      state_d    = RUN;
      expectPc_d = redirectPc_i & ~32'd3;
      line_d     = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (accept) begin
            expectPc_d = (fuPc_i & ~(LINE_BYTES - 32'd1)) + LINE_BYTES;
            if (fuFault_i) begin
              enqValid = 1'b1;
              enqEntry = '{pc: fuPc_i, insn: '0, fault: 1'b1};
              state_d  = HALT;
            end else begin
              line_d    = fuLine_i;
              drainPc_d = fuPc_i;
              state_d   = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (canEnq) begin
            enqValid  = 1'b1;
            enqEntry  = '{pc: drainPc_q, insn: lineWord[drainIdx], fault: 1'b0};
            drainPc_d = drainPc_q + 32'd4;
            if (drainIdx == LAST_IDX) state_d = RUN;
          end
        end
        HALT: ;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstN_i) begin
    if (!rstN_i) begin
      state_q    <= RUN;
      expectPc_q <= RESET_PC;
      drainPc_q  <= '0;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      expectPc_q <= expectPc_d;
      drainPc_q  <= drainPc_d;
      line_q     <= line_d;
    end
  end

  fetch_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rstN_i      (rstN_i),
    .clear_i     (redirectValid_i),
    .enq_i       (fifoEnq),
    .enqData_i   (enqEntry),
    .deq_i       (outReady_i),
    .deqData_o   (fifoHead),
    .full_o      (fifoFull),
    .empty_o     (fifoEmpty),
    .freeCount_o (freeCount)
  );

`ifdef FETCH_INSN_QUEUE_BYPASS_EN
  // An entry bypassing an empty queue and taken at once never occupies a slot.
  assign fifoEnq    = enqValid && !(fifoEmpty && outReady_i);
  assign outValid_o = !fifoEmpty || enqValid;
  assign headEntry  = fifoEmpty ? enqEntry : fifoHead;
`else
  assign fifoEnq    = enqValid;
  assign outValid_o = !fifoEmpty;
  assign headEntry  = fifoHead;
`endif

  assign outPc_o    = outValid_o ? headEntry.pc    : '0;
  assign outInsn_o  = outValid_o ? headEntry.insn  : '0;
  assign outFault_o = outValid_o && headEntry.fault;

  assign fuFlush_o  = redirectValid_i;
  assign fuNextPc_o = redirectValid_i ? (redirectPc_i & ~32'd3) : expectPc_q;
  assign fuStall_o  = (state_q != RUN) || (freeCount < FC_W'(2));

endmodule

// File: tb/tb_fetch_insn_queue.sv
// Self-checking bench: table-driven first line, directed corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_fetch_insn_queue;
  localparam int LW = 128, DEPTH = 4, WPL = LW / 32, LB = LW / 8;
  localparam logic [31:0] RPC = 32'h8000_0000;
`ifdef FETCH_INSN_QUEUE_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN, rv, fv, ff, ordy;
  logic [31:0] rpc, fpc;
  logic [LW-1:0] line;
  logic [31:0] fuNextPc, outPc, outInsn;
  logic fuFlush, fuStall, outValid, outFault;

  fetch_insn_queue #(.LINE_WIDTH(LW), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk_i(clk), .rstN_i(rstN), .redirectValid_i(rv), .redirectPc_i(rpc),
    .fuNextPc_o(fuNextPc), .fuFlush_o(fuFlush), .fuStall_o(fuStall),
    .fuValid_i(fv), .fuFault_i(ff), .fuPc_i(fpc), .fuLine_i(line),
    .outValid_o(outValid), .outReady_i(ordy), .outPc_o(outPc),
    .outInsn_o(outInsn), .outFault_o(outFault));

  typedef struct packed { logic [31:0] pc; logic [31:0] insn; logic fault; } ent_t;
  typedef struct {
    logic fv; logic [31:0] fpc;
    logic ev; logic [31:0] epc; logic [31:0] einsn; logic [31:0] enext; logic estall;
  } vec_t;

  int total = 0, bad = 0;
  ent_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Compare a completed handshake against the front of the expected stream.
  task automatic hs();
    ent_t e;
    if (outValid && ordy) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out: got pc %h insn %h want nothing", outPc, outInsn);
      end else begin
        e = exp_q.pop_front();
        chk("out_pc", outPc, e.pc);
        chk("out_insn", outInsn, e.insn);
        chk1("out_fault", outFault, e.fault);
      end
    end
  endtask

  task automatic at_neg(); @(negedge clk); hs(); endtask
  task automatic nxt();    @(posedge clk); #1;  endtask

  task automatic idle();
    rv = 0; rpc = '0; fv = 0; ff = 0; fpc = '0; line = '0;
  endtask

  function automatic vec_t mk(logic f, logic [31:0] p, logic v, logic [31:0] op,
                              logic [31:0] oi, logic [31:0] nx, logic st);
    vec_t r;
    r.fv = f; r.fpc = p; r.ev = v; r.epc = op; r.einsn = oi; r.enext = nx; r.estall = st;
    return r;
  endfunction

  function automatic ent_t ent(logic [31:0] p, logic [31:0] i, logic f);
    ent_t e;
    e.pc = p; e.insn = i; e.fault = f;
    return e;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[9];
    logic [LW-1:0] l1;
    logic [31:0] wa, wb, wc, wd;
    logic [31:0] m_exp, pend_pc;
    bit pend, halted, real_rsp;
    int k, off;

    wa = 32'hA0A0_0001; wb = 32'hB0B0_0002; wc = 32'hC0C0_0003; wd = 32'hD0D0_0004;
    l1 = {wd, wc, wb, wa};
    vt[0] = mk(0, '0,  0, '0,       '0, RPC,        0);
    vt[1] = mk(1, RPC, 0, '0,       '0, RPC,        0);
    vt[2] = mk(0, '0,  0, '0,       '0, RPC + 16,   1);
    vt[3] = mk(0, '0,  1, RPC,      wa, RPC + 16,   1);
    vt[4] = mk(0, '0,  1, RPC + 4,  wb, RPC + 16,   1);
    vt[5] = mk(0, '0,  1, RPC + 8,  wc, RPC + 16,   1);
    vt[6] = mk(0, '0,  1, RPC + 12, wd, RPC + 16,   0);
    vt[7] = mk(0, '0,  0, '0,       '0, RPC + 16,   0);
    vt[8] = mk(0, '0,  0, '0,       '0, RPC + 16,   0);

    // Reset state
    rstN = 0; idle(); ordy = 1;
    #12;
    chk1("rst_valid", outValid, 0);
    chk("rst_next_pc", fuNextPc, RPC);
    chk1("rst_stall", fuStall, 0);
    chk1("rst_flush", fuFlush, 0);
    chk("rst_out_pc", outPc, 0);
    @(negedge clk); rstN = 1;
    nxt();

    // Test 1: one full line, table driven
    for (int r = 0; r < 9; r++) begin
      idle(); ordy = 1; fv = vt[r].fv; fpc = vt[r].fpc; line = l1;
      @(negedge clk);
      chk("t1_next_pc", fuNextPc, vt[r].enext);
      chk1("t1_stall", fuStall, vt[r].estall);
      k = r + 1 - LAT;
      if (k < 9) begin
        chk1("t1_valid", outValid, vt[k].ev);
        if (vt[k].ev) begin
          chk("t1_pc", outPc, vt[k].epc);
          chk("t1_insn", outInsn, vt[k].einsn);
          chk1("t1_fault", outFault, 0);
        end
      end
      nxt();
    end

    // Test 2: mid-line start only yields words 2 and 3
    idle(); ordy = 1; rv = 1; rpc = RPC + 8;
    at_neg(); chk1("t2_flush", fuFlush, 1); chk("t2_next_redir", fuNextPc, RPC + 8);
    nxt();
    idle(); fv = 1; fpc = RPC + 8; line = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    exp_q.push_back(ent(RPC + 8, 32'h3333_0003, 0));
    exp_q.push_back(ent(RPC + 12, 32'h4444_0004, 0));
    at_neg(); chk1("t2_flush_1cyc", fuFlush, 0);
    nxt(); idle();
    at_neg(); chk1("t2_stall_d1", fuStall, 1); nxt();
    at_neg(); chk1("t2_stall_d2", fuStall, 1); nxt();
    at_neg(); chk1("t2_run_again", fuStall, 0); chk("t2_next_pc", fuNextPc, RPC + 16); nxt();
    at_neg(); nxt();
    chk("t2_drained", 32'(exp_q.size()), 0);

    // Test 3: backpressure, queue fills and holds its head
    idle(); ordy = 0; fv = 1; fpc = RPC + 16;
    line = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};
    for (int w = 0; w < 4; w++) exp_q.push_back(ent(RPC + 16 + 4 * w, 32'h5555_0000 + w, 0));
    at_neg(); nxt(); idle();
    for (int c = 1; c <= 10; c++) begin
      at_neg();
      if (c >= 5) begin
        chk1("t3_stall_full", fuStall, 1);
        chk1("t3_valid_hold", outValid, 1);
        chk("t3_head_steady", outPc, RPC + 16);
      end
      nxt();
    end
    ordy = 1;
    for (int c = 0; c < 8; c++) begin at_neg(); nxt(); end
    chk("t3_no_loss", 32'(exp_q.size()), 0);

    // Test 4: redirect mid-drain, stale response dropped
    idle(); ordy = 1; fv = 1; fpc = RPC + 32;
    line = {32'h6666_0003, 32'h6666_0002, 32'h6666_0001, 32'h6666_0000};
    exp_q.push_back(ent(RPC + 32, 32'h6666_0000, 0));
    at_neg(); nxt(); idle();
    at_neg(); nxt();
    rv = 1; rpc = 32'h8000_0102;
    at_neg(); chk1("t4_flush", fuFlush, 1); chk("t4_next_pc", fuNextPc, 32'h8000_0100);
    nxt(); idle();
    at_neg(); chk1("t4_flush_low", fuFlush, 0); chk1("t4_empty", outValid, 0);
    chk("t4_next_after", fuNextPc, 32'h8000_0100);
    nxt(); fv = 1; fpc = RPC + 16; line = l1;
    at_neg(); chk1("t4_stale_comb", outValid, 0); nxt(); idle();
    at_neg(); chk1("t4_stale_drop", outValid, 0); chk1("t4_stall", fuStall, 0);
    chk("t4_next_kept", fuNextPc, 32'h8000_0100); nxt();
    chk("t4_stream", 32'(exp_q.size()), 0);

    // Test 5: fault entry and HALT until redirect
    idle(); ordy = 0; rv = 1; rpc = 32'h8000_2000;
    at_neg(); nxt(); idle();
    fv = 1; ff = 1; fpc = 32'h8000_2000; line = l1;
    at_neg(); nxt(); idle();
    exp_q.push_back(ent(32'h8000_2000, 32'h0, 1));
    for (int c = 0; c < 4; c++) begin
      at_neg();
      chk1("t5_stall", fuStall, 1); chk1("t5_valid", outValid, 1);
      chk1("t5_fault", outFault, 1); chk("t5_insn0", outInsn, 0);
      chk("t5_pc", outPc, 32'h8000_2000);
      nxt();
    end
    ordy = 1;
    at_neg(); nxt();
    fv = 1; fpc = 32'h8000_2010; line = l1;
    at_neg(); chk1("t5_halt_noacc", outValid, 0); chk1("t5_halt_stall", fuStall, 1); nxt(); idle();
    at_neg(); chk1("t5_halt_empty", outValid, 0); nxt();
    rv = 1; rpc = RPC;
    at_neg(); nxt(); idle();
    at_neg(); chk1("t5_resume", fuStall, 0); nxt();
    chk("t5_stream", 32'(exp_q.size()), 0);

    // Test 6: async reset while draining into a full queue
    idle(); ordy = 0; fv = 1; fpc = RPC; line = l1;
    at_neg(); nxt(); idle();
    for (int c = 0; c < 4; c++) begin at_neg(); nxt(); end
    fv = 1; fpc = RPC + 16; line = l1;
    at_neg(); nxt(); idle();
    at_neg(); chk1("t6_full_stall", fuStall, 1); chk1("t6_full_valid", outValid, 1); nxt();
    @(posedge clk); #2 rstN = 0; #1;
    chk1("t6_rst_valid", outValid, 0); chk("t6_rst_pc", outPc, 0);
    chk("t6_rst_insn", outInsn, 0); chk1("t6_rst_fault", outFault, 0);
    chk("t6_rst_next", fuNextPc, RPC); chk1("t6_rst_stall", fuStall, 0);
    chk1("t6_rst_flush", fuFlush, 0);
    exp_q.delete();
    @(negedge clk); @(negedge clk); rstN = 1;
    nxt();

    // Randomized traffic; bench acts as a one-request-at-a-time fetch unit
    m_exp = RPC; pend = 0; pend_pc = '0; halted = 0;
    for (int c = 0; c < 3000; c++) begin
      idle();
      rv = ($urandom_range(0, 39) == 0) || (halted && $urandom_range(0, 5) == 0);
      rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                        : RPC + 32'($urandom_range(0, 255));
      real_rsp = pend;
      if (pend) begin
        fv = 1; fpc = pend_pc; ff = ($urandom_range(0, 15) == 0); pend = 0;
      end else if ($urandom_range(0, 9) == 0) begin
        fv = 1; fpc = m_exp ^ 32'h0000_0100; ff = 1'($urandom_range(0, 1));
      end
      line = {$urandom, $urandom, $urandom, $urandom};
      ordy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      chk1("rnd_flush", fuFlush, rv);
      chk("rnd_next_pc", fuNextPc, rv ? (rpc & ~32'd3) : m_exp);
      if (halted) chk1("rnd_halt_stall", fuStall, 1);
      hs();
      if (!fuStall && !rv && !real_rsp && $urandom_range(0, 1) == 1) begin
        pend = 1; pend_pc = m_exp;
      end
      if (rv) begin
        exp_q.delete(); m_exp = rpc & ~32'd3; halted = 0;
      end else if (fv && fpc == m_exp && !halted) begin
        if (ff) begin
          exp_q.push_back(ent(fpc, 32'h0, 1)); halted = 1;
        end else begin
          off = int'(fpc % LB) / 4;
          for (int w = off; w < WPL; w++)
            exp_q.push_back(ent(fpc + 32'(4 * (w - off)), line[32 * w +: 32], 0));
        end
        m_exp = fpc - (fpc % LB) + LB;
      end
      nxt();
    end

    idle(); ordy = 1;
    for (int c = 0; c < 100; c++) begin
      at_neg(); nxt();
      if (exp_q.size() == 0 && !outValid) break;
    end
    chk("rnd_stream_left", 32'(exp_q.size()), 0);
    chk1("rnd_final_empty", outValid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
